// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the HI/LO multiply/divide unit.
// Command codes, FSM states and the divide iteration count.
package mdu_pkg;

    localparam int DIV_ITERS = 32;

    localparam logic [1:0] MDU_NONE     = 2'b00;
    localparam logic [1:0] MDU_SIGNED   = 2'b01;
    localparam logic [1:0] MDU_UNSIGNED = 2'b10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_DIV  = 1'b1
    } mdu_state_t;

    // Only 01 and 10 are real commands; 00 and 11 mean nothing.
    function automatic logic cmd_valid(input logic [1:0] c);
        return (c == MDU_SIGNED) || (c == MDU_UNSIGNED);
    endfunction

endpackage

// File: rtl/div_restoring.sv
// div_restoring: 32-step restoring divider on operand magnitudes.
// Emits sign-fixed quotient/remainder during the final step.
module div_restoring #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        fin,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    import mdu_pkg::*;

    mdu_state_t  state;
    mdu_state_t  state_n;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] raw_a;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        ok;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign a_mag = (is_signed && dividend[31]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[31])  ? -divisor  : divisor;

    // One restoring step: the 33-bit trial borrows exactly when
    // the shifted remainder is smaller than the divisor.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, dvs};
    assign ok      = ~trial[32];
    assign rem_n   = ok ? trial[31:0] : shifted[31:0];
    assign quo_n   = {quo[30:0], ok};

    assign busy = (state == MDU_DIV);
    assign fin  = busy && (cnt == 6'(ITERS - 1));

    // Sign fix, or the divide-by-zero override, on the final step.
    always_comb begin
        quotient  = neg_q ? -quo_n : quo_n;
        remainder = neg_r ? -rem_n : rem_n;
        if (dz) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = raw_a;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MDU_IDLE;
        else       state <= state_n;
    end

    // Next state: leave IDLE on start, return after the last step.
    always_comb begin
        state_n = state;
        unique case (state)
            MDU_IDLE: if (start) state_n = MDU_DIV;
            MDU_DIV:  if (fin)   state_n = MDU_IDLE;
            default:             state_n = MDU_IDLE;
        endcase
    end

    // Operand latch on start, then one iteration per DIV cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            raw_a <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (state == MDU_IDLE) begin
            if (start) begin
                cnt   <= '0;
                rem   <= '0;
                quo   <= a_mag;
                dvs   <= b_mag;
                raw_a <= dividend;
                neg_q <= is_signed && (dividend[31] ^ divisor[31]);
                neg_r <= is_signed && dividend[31];
                dz    <= (divisor == 32'd0);
            end
        end else begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= fin ? 6'd0 : cnt + 6'd1;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO registers, single-cycle multiplier and
// arbitration in front of the iterative divider.
module mul_div_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mul_con,
    input  logic [1:0]  div_con,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] hilo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    import mdu_pkg::*;

    logic        mul_v;
    logic        div_v;
    logic        start;
    logic        fin;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] prod;

    assign mul_v = cmd_valid(mul_con);
    assign div_v = cmd_valid(div_con);
    assign start = !busy && div_v && !mul_v;

    always_comb begin
        if (mul_con == MDU_SIGNED)
            prod = $signed({{32{src_a[31]}}, src_a})
                 * $signed({{32{src_b[31]}}, src_b});
        else
            prod = {32'd0, src_a} * {32'd0, src_b};
    end

    div_restoring #(
        .ITERS(DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (div_con == MDU_SIGNED),
        .dividend  (src_a),
        .divisor   (src_b),
        .busy      (busy),
        .fin       (fin),
        .quotient  (q),
        .remainder (r)
    );

    // HI/LO writes: divide result, then mul > div > MTHI/MTLO in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                hi <= r;
                lo <= q;
            end else if (!busy) begin
                if (mul_v) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else if (!div_v) begin
                    if (hilo_we[1]) hi <= hilo_wdata;
                    if (hilo_we[0]) lo <= hilo_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors, arithmetic reference model
// compared every cycle, plus literal checks on key results.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mul_con;
    logic [1:0]  div_con;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  hilo_we;
    logic [31:0] hilo_wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mul_con    (mul_con),
        .div_con    (div_con),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [63:0] div_ref(input logic sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint la, lb, lq, lr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            return {lr[31:0], lq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [63:0] mul_ref(input logic sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint la, lb;
        logic [63:0] ua, ub;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            return 64'(la * lb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic bit valid(input logic [1:0] c);
        return c == 2'b01 || c == 2'b10;
    endfunction

    // Reference model: remaining-cycle countdown for divides.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_pend;
                m_done = 1'b1;
            end
        end else if (valid(mul_con)) begin
            {m_hi, m_lo} = mul_ref(mul_con == 2'b01, src_a, src_b);
        end else if (valid(div_con)) begin
            m_pend = div_ref(div_con == 2'b01, src_a, src_b);
            m_left = 32;
        end else begin
            if (hilo_we[1]) m_hi = hilo_wdata;
            if (hilo_we[0]) m_lo = hilo_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
        end
    end

    task automatic issue(input logic [1:0] m, input logic [1:0] d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] we, input logic [31:0] wd);
        @(negedge clk);
        mul_con = m;
        div_con = d;
        src_a = a;
        src_b = b;
        hilo_we = we;
        hilo_wdata = wd;
        @(negedge clk);
        mul_con = 2'b00;
        div_con = 2'b00;
        hilo_we = 2'b00;
    endtask

    task automatic wait_done(output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int nb;
        bit seen;
        reset = 1'b1;
        mul_con = '0;
        div_con = '0;
        src_a = '0;
        src_b = '0;
        hilo_we = '0;
        hilo_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;

        issue(2'b01, 2'b00, 32'hFFFF_FFFE, 32'd3, 2'b00, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        issue(2'b10, 2'b00, 32'hFFFF_FFFE, 32'd3, 2'b00, 0);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        issue(2'b00, 2'b10, 32'd100, 32'd7, 2'b00, 0);
        wait_done(nb);
        chk("divu_busy_cycles", nb, 32'd32);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);

        issue(2'b00, 2'b01, 32'hFFFF_FFF9, 32'd2, 2'b00, 0);
        wait_done(nb);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0);
        wait_done(nb);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        issue(2'b00, 2'b10, 32'd5, 32'd0, 2'b00, 0);
        wait_done(nb);
        chk("dz_busy_cycles", nb, 32'd32);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'd5);

        issue(2'b00, 2'b01, 32'hFFFF_FFF0, 32'd0, 2'b00, 0);
        wait_done(nb);
        chk("sdz_lo", lo, 32'hFFFF_FFFF);
        chk("sdz_hi", hi, 32'hFFFF_FFF0);

        issue(2'b00, 2'b10, 32'd100, 32'd7, 2'b00, 0);
        repeat (3) @(negedge clk);
        mul_con = 2'b01;
        src_a = 32'd1000;
        src_b = 32'd1000;
        hilo_we = 2'b11;
        hilo_wdata = 32'h1234;
        @(negedge clk);
        mul_con = 2'b00;
        hilo_we = 2'b00;
        wait_done(nb);
        chk("ign_lo", lo, 32'd14);
        chk("ign_hi", hi, 32'd2);

        issue(2'b00, 2'b00, 0, 0, 2'b01, 32'hABCD);
        chk("mtlo_lo", lo, 32'hABCD);
        chk("mtlo_hi", hi, 32'd2);
        issue(2'b00, 2'b00, 0, 0, 2'b10, 32'h5555);
        chk("mthi_hi", hi, 32'h5555);

        issue(2'b01, 2'b01, 32'd6, 32'd7, 2'b11, 32'h9);
        chk("both_lo", lo, 32'd42);
        chk("both_busy", {31'd0, busy}, 32'd0);

        issue(2'b00, 2'b10, 32'd100, 32'd7, 2'b00, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        issue(2'b00, 2'b10, 32'd9, 32'd3, 2'b00, 0);
        wait_done(nb);
        chk("post_lo", lo, 32'd3);
        chk("post_hi", hi, 32'd0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
